// File: rtl/bow_pkg.sv
// Shared types for the BoW receive link buffer: APB phase encoding, entry layout, parity helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package bow_pkg;

  localparam int BOW_DW = 16;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

  // One buffered link word: sideband bit travels with its data.
  typedef struct packed {
    logic              aux;
    logic [BOW_DW-1:0] data;
  } bow_entry_t;

  localparam int BOW_ENTRY_W = $bits(bow_entry_t);

  // Even parity over data plus fec bit; nonzero means the word is corrupt.
  function automatic logic parity_bad(input logic [BOW_DW-1:0] d, input logic fec);
    return (^d) ^ fec;
  endfunction

endpackage

// File: rtl/bow_sync_fifo.sv
// Single-clock FIFO with show-ahead read port, occupancy level and full/empty.
// Latency: a write is visible on rd_dat/rd_vld the cycle after it is taken.
// Backpressure: full is registered (from level); writes while full and pops while empty are ignored.
// Ports: clk/rst (sync, active-high); wr_vld/wr_dat write side; rd_rdy pop, rd_vld/rd_dat head;
//        full, level (0..DEPTH).
module bow_sync_fifo
  import bow_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = BOW_ENTRY_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  output logic          full,
  input  logic          rd_rdy,
  output logic          rd_vld,
  output logic [W-1:0]  rd_dat,
  output logic [AW:0]   level
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic          wr_fire;
  logic          rd_fire;

  assign full    = (level_q == LVL_FULL);
  assign rd_vld  = (level_q != '0);
  assign wr_fire = wr_vld & ~full;
  assign rd_fire = rd_rdy & rd_vld;
  assign level   = level_q;
  // Head is forced to zero while empty so stale storage never shows on the port.
  assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/bow_rx_link_buffer.sv
// Receive link stage: completes APB writes from the link, parity-checks them, buffers them for the core.
// Latency: an accepted word appears on rd_valid/rd_data the next cycle.
// Backpressure: pready_rx = ~full (registered level); the link waits in ACCESS until space frees up.
// Ports: pclk_rx/preset (sync, active-high); psel_rx/penable_rx/pwrite_rx/data_link/fec_link/aux_link
//        APB write side; pready_rx/pslverr_rx responses; rd_en pop, rd_valid/rd_data/rd_aux head;
//        level occupancy; proto_err sticky protocol flag; par_err_cnt dropped-word counter.
// Build option: BOW_RX_PARITY_CHECK_EN enables fec checking, pslverr_rx and par_err_cnt.
module bow_rx_link_buffer
  import bow_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = BOW_DW
) (
  input  logic          pclk_rx,
  input  logic          preset,
  input  logic          psel_rx,
  input  logic          penable_rx,
  input  logic          pwrite_rx,
  input  logic [DW-1:0] data_link,
  input  logic          fec_link,
  input  logic          aux_link,
  output logic          pready_rx,
  output logic          pslverr_rx,
  input  logic          rd_en,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_aux,
  output logic [AW:0]   level,
  output logic          proto_err,
  output logic [7:0]    par_err_cnt
);

  apb_state_t state_q;
  apb_state_t state_d;
  logic       done_q;     // previous cycle completed a transfer
  logic       proto_hit;
  logic       complete;
  logic       accept;
  logic       store;
  logic       full;
  bow_entry_t wr_entry;
  bow_entry_t head;

  assign pready_rx = ~full;

  // ACCESS entered without SETUP (from IDLE, or straight after a completed
  // transfer) is flagged but still served as a normal transfer.
  always_comb begin
    state_d   = state_q;
    proto_hit = 1'b0;
    case (state_q)
      APB_IDLE: begin
        if (psel_rx && !penable_rx) begin
          state_d = APB_SETUP;
        end else if (psel_rx && penable_rx) begin
          state_d   = APB_ACCESS;
          proto_hit = 1'b1;
        end
      end
      APB_SETUP: begin
        if (!psel_rx)        state_d = APB_IDLE;
        else if (penable_rx) state_d = APB_ACCESS;
      end
      APB_ACCESS: begin
        if (!psel_rx) begin
          state_d = APB_IDLE;
        end else if (!penable_rx) begin
          state_d = APB_SETUP;
        end else begin
          state_d   = APB_ACCESS;
          proto_hit = done_q;
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  assign complete = (state_d == APB_ACCESS) && psel_rx && penable_rx && pready_rx;
  assign accept   = complete && pwrite_rx;

  always_ff @(posedge pclk_rx) begin
    if (preset) begin
      state_q   <= APB_IDLE;
      done_q    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= complete;
      if (proto_hit) proto_err <= 1'b1;
    end
  end

`ifdef BOW_RX_PARITY_CHECK_EN
  logic drop;

  assign drop       = accept && parity_bad(data_link, fec_link);
  assign store      = accept && !drop;
  assign pslverr_rx = drop;

  always_ff @(posedge pclk_rx) begin
    if (preset) begin
      par_err_cnt <= 8'd0;
    end else if (drop && (par_err_cnt != 8'hFF)) begin
      par_err_cnt <= par_err_cnt + 8'd1;
    end
  end
`else
  logic unused_fec;

  assign unused_fec  = fec_link;
  assign store       = accept;
  assign pslverr_rx  = 1'b0;
  assign par_err_cnt = 8'd0;
`endif

  assign wr_entry = '{aux: aux_link, data: data_link};

  bow_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (BOW_ENTRY_W)
  ) u_fifo (
    .clk    (pclk_rx),
    .rst    (preset),
    .wr_vld (store),
    .wr_dat (wr_entry),
    .full   (full),
    .rd_rdy (rd_en),
    .rd_vld (rd_valid),
    .rd_dat (head),
    .level  (level)
  );

  assign rd_data = head.data;
  assign rd_aux  = head.aux;

endmodule

// File: tb/tb_bow_rx_link_buffer.sv
// Bench for bow_rx_link_buffer: directed scenarios plus randomized traffic against a queue model.
// Latency: inputs driven on negedge, outputs sampled on negedge (or #1 after it for combinational responses).
// Backpressure: link transfers wait on pready_rx with bounded cycle budgets.
module tb_bow_rx_link_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef BOW_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        pclk_rx = 1'b0;
  logic        preset, psel_rx, penable_rx, pwrite_rx, fec_link, aux_link, rd_en;
  logic [15:0] data_link;
  logic        pready_rx, pslverr_rx, rd_valid, rd_aux, proto_err;
  logic [15:0] rd_data;
  logic [AW:0] level;
  logic [7:0]  par_err_cnt;

  int errors = 0;
  int checks = 0;
  logic [16:0] model_q[$];
  int exp_par_cnt = 0;

  always #5 pclk_rx = ~pclk_rx;

  bow_rx_link_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(16)) dut (
    .pclk_rx(pclk_rx), .preset(preset), .psel_rx(psel_rx), .penable_rx(penable_rx),
    .pwrite_rx(pwrite_rx), .data_link(data_link), .fec_link(fec_link), .aux_link(aux_link),
    .pready_rx(pready_rx), .pslverr_rx(pslverr_rx), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_aux(rd_aux), .level(level), .proto_err(proto_err),
    .par_err_cnt(par_err_cnt)
  );

  // Reference: a completed write is stored unless parity checking is built in and parity is odd.
  task automatic model_accept(input logic [15:0] d, input logic f, input logic a, input logic w);
    bit bad;
    bad = ((^d) != f);
    if (w) begin
      if (PAR_EN && bad) begin
        if (exp_par_cnt < 255) exp_par_cnt++;
      end else begin
        model_q.push_back({a, d});
      end
    end
  endtask

  // SETUP then ACCESS, waiting up to max_wait cycles for pready. Starts and ends on a negedge.
  task automatic apb_xfer(input logic [15:0] d, input logic f, input logic a, input logic w,
                          input int max_wait, output bit done, output bit err);
    int waited;
    psel_rx = 1'b1; penable_rx = 1'b0; pwrite_rx = w;
    data_link = d; fec_link = f; aux_link = a;
    @(negedge pclk_rx);
    penable_rx = 1'b1;
    #1;
    waited = 0;
    while (pready_rx !== 1'b1 && waited < max_wait) begin
      @(negedge pclk_rx); #1;
      waited++;
    end
    done = (pready_rx === 1'b1);
    err  = (pslverr_rx === 1'b1);
    if (done) model_accept(d, f, a, w);
    @(negedge pclk_rx);
    psel_rx = 1'b0; penable_rx = 1'b0; pwrite_rx = 1'b0;
  endtask

  task automatic test_reset;
    preset = 1'b1; psel_rx = 0; penable_rx = 0; pwrite_rx = 0;
    data_link = '0; fec_link = 0; aux_link = 0; rd_en = 0;
    repeat (2) @(negedge pclk_rx);
    checks++; if (pready_rx !== 1'b1) begin errors++; $display("FAIL reset_pready: got %0b want 1", pready_rx); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %0b want 0", proto_err); end
    checks++; if (rd_data !== 16'h0 || rd_aux !== 1'b0) begin errors++; $display("FAIL reset_rd_data: got %h/%0b want 0/0", rd_data, rd_aux); end
    checks++; if (pslverr_rx !== 1'b0 || par_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_par: got %0b/%0d want 0/0", pslverr_rx, par_err_cnt); end
    preset = 1'b0;
    model_q.delete();
    exp_par_cnt = 0;
  endtask

  task automatic test_single;
    bit done, err;
    apb_xfer(16'hA5A5, 1'b0, 1'b1, 1'b1, 4, done, err);
    checks++; if (!done || err) begin errors++; $display("FAIL single_xfer: done=%0b err=%0b want 1/0", done, err); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hA5A5 || rd_aux !== 1'b1) begin
      errors++; $display("FAIL single_head: got v=%0b d=%h a=%0b want 1/a5a5/1", rd_valid, rd_data, rd_aux); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level: got %0d want 1", level); end
    rd_en = 1'b1;
    @(negedge pclk_rx);
    rd_en = 1'b0;
    void'(model_q.pop_front());
    checks++; if (level !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got lvl=%0d v=%0b want 0/0", level, rd_valid); end
  endtask

  task automatic test_fill;
    bit done, err;
    logic [15:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      d = 16'(i);
      apb_xfer(d, ^d, d[0], 1'b1, 4, done, err);
      checks++; if (!done) begin errors++; $display("FAIL fill_xfer%0d: done=%0b want 1", i, done); end
    end
    checks++; if (pready_rx !== 1'b0 || level !== 5'd16) begin errors++; $display("FAIL fill_full: got rdy=%0b lvl=%0d want 0/16", pready_rx, level); end
    // 17th transfer parks in ACCESS
    d = 16'hBEEF;
    psel_rx = 1'b1; penable_rx = 1'b0; pwrite_rx = 1'b1; data_link = d; fec_link = ^d; aux_link = 1'b0;
    @(negedge pclk_rx);
    penable_rx = 1'b1;
    repeat (3) @(negedge pclk_rx);
    checks++; if (pready_rx !== 1'b0 || level !== 5'd16) begin errors++; $display("FAIL fill_stall: got rdy=%0b lvl=%0d want 0/16", pready_rx, level); end
    rd_en = 1'b1;
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL fill_head: got %h want 0000", rd_data); end
    @(negedge pclk_rx);
    rd_en = 1'b0;
    void'(model_q.pop_front());
    checks++; if (pready_rx !== 1'b1 || level !== 5'd15) begin errors++; $display("FAIL fill_space: got rdy=%0b lvl=%0d want 1/15", pready_rx, level); end
    model_accept(d, ^d, 1'b0, 1'b1);
    @(negedge pclk_rx);
    psel_rx = 1'b0; penable_rx = 1'b0; pwrite_rx = 1'b0;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_17th: got lvl=%0d want 16", level); end
    rd_en = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== model_q[0][15:0] || rd_aux !== model_q[0][16]) begin
        errors++; $display("FAIL fill_drain%0d: got v=%0b d=%h a=%0b want d=%h a=%0b", k, rd_valid, rd_data, rd_aux, model_q[0][15:0], model_q[0][16]);
      end
      void'(model_q.pop_front());
      @(negedge pclk_rx);
    end
    rd_en = 1'b0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL fill_empty: got lvl=%0d want 0", level); end
  endtask

  task automatic test_wrap;
    bit wr_done;
    int max_lvl;
    wr_done = 1'b0;
    max_lvl = 0;
    rd_en = 1'b1;
    fork
      begin
        bit done, err;
        logic [15:0] d;
        for (int i = 0; i < 40; i++) begin
          d = 16'($urandom);
          apb_xfer(d, ^d, 1'($urandom), 1'b1, 4, done, err);
          checks++; if (!done) begin errors++; $display("FAIL wrap_xfer%0d: done=0 want 1", i); end
        end
        wr_done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(wr_done && model_q.size() == 0) && cyc < 400) begin
          @(negedge pclk_rx);
          if (int'(level) > max_lvl) max_lvl = int'(level);
          if (rd_valid === 1'b1) begin
            checks++;
            if (model_q.size() == 0 || rd_data !== model_q[0][15:0] || rd_aux !== model_q[0][16]) begin
              errors++; $display("FAIL wrap_order: got d=%h a=%0b model size=%0d", rd_data, rd_aux, model_q.size());
            end
            if (model_q.size() != 0) void'(model_q.pop_front());
          end
          cyc++;
        end
        checks++; if (cyc >= 400) begin errors++; $display("FAIL wrap_timeout: cycles=%0d limit 400", cyc); end
      end
    join
    @(negedge pclk_rx);
    rd_en = 1'b0;
    checks++; if (max_lvl > 1) begin errors++; $display("FAIL wrap_level: got max %0d want <=1", max_lvl); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL wrap_empty: got %0d want 0", level); end
  endtask

  task automatic test_parity;
    bit done, err;
    int n;
    apb_xfer(16'h0001, 1'b0, 1'b0, 1'b1, 4, done, err);
`ifdef BOW_RX_PARITY_CHECK_EN
    checks++; if (!done || !err) begin errors++; $display("FAIL par_bad_err: done=%0b err=%0b want 1/1", done, err); end
    checks++; if (level !== 5'd0 || par_err_cnt !== 8'd1) begin errors++; $display("FAIL par_bad_drop: lvl=%0d cnt=%0d want 0/1", level, par_err_cnt); end
`else
    checks++; if (!done || err) begin errors++; $display("FAIL par_off_err: done=%0b err=%0b want 1/0", done, err); end
    checks++; if (level !== 5'd1 || par_err_cnt !== 8'd0) begin errors++; $display("FAIL par_off_store: lvl=%0d cnt=%0d want 1/0", level, par_err_cnt); end
`endif
    apb_xfer(16'h0001, 1'b1, 1'b1, 1'b1, 4, done, err);
    checks++; if (!done || err) begin errors++; $display("FAIL par_good: done=%0b err=%0b want 1/0", done, err); end
    checks++; if (level !== 5'(model_q.size())) begin errors++; $display("FAIL par_level: got %0d want %0d", level, model_q.size()); end
    n = model_q.size();
    rd_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== model_q[0][15:0] || rd_aux !== model_q[0][16]) begin
        errors++; $display("FAIL par_drain%0d: got v=%0b d=%h a=%0b want d=%h a=%0b", k, rd_valid, rd_data, rd_aux, model_q[0][15:0], model_q[0][16]);
      end
      void'(model_q.pop_front());
      @(negedge pclk_rx);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_protocol;
    bit done, err;
    @(negedge pclk_rx);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_pre: got %0b want 0", proto_err); end
    psel_rx = 1'b1; penable_rx = 1'b1; pwrite_rx = 1'b1;
    data_link = 16'h1234; fec_link = ^data_link; aux_link = 1'b1;
    #1;
    checks++; if (pready_rx !== 1'b1) begin errors++; $display("FAIL proto_ready: got %0b want 1", pready_rx); end
    model_accept(16'h1234, ^16'h1234, 1'b1, 1'b1);
    @(negedge pclk_rx);
    psel_rx = 1'b0; penable_rx = 1'b0; pwrite_rx = 1'b0;
    checks++; if (proto_err !== 1'b1 || level !== 5'd1) begin errors++; $display("FAIL proto_flag: err=%0b lvl=%0d want 1/1", proto_err, level); end
    // A read transfer completes but stores nothing; the flag stays set.
    apb_xfer(16'h7777, 1'b0, 1'b0, 1'b0, 4, done, err);
    checks++; if (!done || level !== 5'd1 || proto_err !== 1'b1) begin errors++; $display("FAIL proto_read: done=%0b lvl=%0d err=%0b want 1/1/1", done, level, proto_err); end
    checks++; if (rd_data !== 16'h1234 || rd_aux !== 1'b1) begin errors++; $display("FAIL proto_word: got %h/%0b want 1234/1", rd_data, rd_aux); end
    preset = 1'b1;
    @(negedge pclk_rx);
    preset = 1'b0;
    model_q.delete(); exp_par_cnt = 0;
    checks++; if (proto_err !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL proto_clear: err=%0b lvl=%0d want 0/0", proto_err, level); end
  endtask

  task automatic test_reset_mid;
    bit done, err;
    for (int i = 0; i < 3; i++) apb_xfer(16'(16'h100 + i), ^(16'(16'h100 + i)), 1'b1, 1'b1, 4, done, err);
    psel_rx = 1'b1; penable_rx = 1'b0; pwrite_rx = 1'b1; data_link = 16'h5555; fec_link = 1'b0;
    @(negedge pclk_rx);
    penable_rx = 1'b1; preset = 1'b1;
    @(negedge pclk_rx);
    preset = 1'b0; psel_rx = 1'b0; penable_rx = 1'b0; pwrite_rx = 1'b0;
    model_q.delete(); exp_par_cnt = 0;
    checks++; if (level !== 5'd0 || rd_valid !== 1'b0 || pready_rx !== 1'b1 || rd_data !== 16'h0) begin
      errors++; $display("FAIL reset_mid: lvl=%0d v=%0b rdy=%0b d=%h want 0/0/1/0000", level, rd_valid, pready_rx, rd_data); end
  endtask

  task automatic test_random;
    bit wr_done;
    int lvl_bad;
    wr_done = 1'b0;
    lvl_bad = 0;
    fork
      begin
        bit done, err, w, f, exp_err;
        logic [15:0] d;
        for (int i = 0; i < 60; i++) begin
          d = 16'($urandom);
          w = ($urandom_range(0, 4) != 0);
          f = ($urandom_range(0, 3) == 0) ? ~^d : ^d;
          exp_err = PAR_EN && w && ((^d) != f);
          apb_xfer(d, f, 1'($urandom), w, 200, done, err);
          checks++; if (!done || err !== exp_err) begin errors++; $display("FAIL rand_xfer%0d: done=%0b err=%0b want 1/%0b", i, done, err, exp_err); end
          repeat ($urandom_range(0, 2)) @(negedge pclk_rx);
        end
        wr_done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(wr_done && model_q.size() == 0) && cyc < 3000) begin
          @(negedge pclk_rx);
          if (level !== 5'(model_q.size())) lvl_bad++;
          rd_en = wr_done ? 1'b1 : 1'($urandom_range(0, 1));
          if (rd_en && rd_valid === 1'b1) begin
            checks++;
            if (model_q.size() == 0 || rd_data !== model_q[0][15:0] || rd_aux !== model_q[0][16]) begin
              errors++; $display("FAIL rand_order: got d=%h a=%0b model size=%0d", rd_data, rd_aux, model_q.size());
            end
            if (model_q.size() != 0) void'(model_q.pop_front());
          end
          cyc++;
        end
        checks++; if (cyc >= 3000) begin errors++; $display("FAIL rand_timeout: cycles=%0d limit 3000", cyc); end
      end
    join
    @(negedge pclk_rx);
    rd_en = 1'b0;
    checks++; if (lvl_bad != 0) begin errors++; $display("FAIL rand_level: %0d cycles disagreed with model occupancy", lvl_bad); end
    checks++; if (par_err_cnt !== 8'(exp_par_cnt)) begin errors++; $display("FAIL rand_par_cnt: got %0d want %0d", par_err_cnt, exp_par_cnt); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rand_empty: got %0d want 0", level); end
  endtask

`ifdef BOW_RX_PARITY_CHECK_EN
  task automatic test_saturate;
    bit done, err;
    for (int i = 0; i < 260; i++) apb_xfer(16'h0001, 1'b0, 1'b0, 1'b1, 4, done, err);
    checks++; if (par_err_cnt !== 8'd255 || exp_par_cnt != 255) begin errors++; $display("FAIL par_saturate: got %0d want 255", par_err_cnt); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL par_sat_level: got %0d want 0", level); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_parity();
    test_protocol();
    test_reset_mid();
    test_random();
`ifdef BOW_RX_PARITY_CHECK_EN
    test_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
